// File: rtl/pipe_hazard_ctrl.sv
// Pipeline interlock and flush controller: load-use, HI/LO multiplier interlock, taken-branch squash and CP0 flush.
// Optional macro PIPE_MUL_INTERLOCK_EN enables the multiplier occupancy counter and its interlock term.
module pipe_hazard_ctrl #(
    parameter int MUL_LAT   = 4,
    parameter int FLUSH_CYC = 2
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [4:0]  id_Ra,
    input  logic [4:0]  id_Rb,
    input  logic        id_useRa,
    input  logic        id_useRb,
    input  logic        id_valid,
    input  logic        id_mulRead,
    input  logic [1:0]  id_regToMul,
    input  logic        id_mulCtr,
    input  logic        id_branchTaken,
    input  logic [4:0]  ex_Rw,
    input  logic        ex_RegWr,
    input  logic        ex_valid,
    input  logic [1:0]  ex_MemRead,
    input  logic        ex_mulCtr,
    input  logic        cp0_flush,
    output logic        hazard,
    output logic        BranchBubble,
    output logic        cp0Bubble,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        mul_busy,
    output logic [15:0] stall_cnt
);

    logic       lu;
    logic       mh;
    logic [2:0] fcnt;

    assign lu = ex_valid & ex_RegWr & (ex_MemRead != 2'b00) & (ex_Rw != 5'd0) & id_valid &
                ((id_useRa & (id_Ra == ex_Rw)) | (id_useRb & (id_Rb == ex_Rw)));

`ifdef PIPE_MUL_INTERLOCK_EN
    logic [3:0] mcnt;

    // A new mult reloads the counter even if a previous one is still in flight.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            mcnt <= 4'd0;
        end else if (ex_valid & ex_mulCtr) begin
            mcnt <= 4'(MUL_LAT);
        end else if (mcnt != 4'd0) begin
            mcnt <= mcnt - 4'd1;
        end
    end

    assign mul_busy = (mcnt != 4'd0);
    assign mh       = mul_busy & id_valid & (id_mulRead | id_mulCtr | (id_regToMul != 2'b00));
`else
    logic unused_mul;

    assign unused_mul = ^{id_mulRead, id_mulCtr, id_regToMul, ex_mulCtr};
    assign mul_busy   = 1'b0;
    assign mh         = 1'b0;
`endif

    // Flush requests during an active flush restart the window; the multiplier is left running.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            fcnt      <= 3'd0;
            stall_cnt <= 16'd0;
        end else begin
            if (cp0_flush) begin
                fcnt <= 3'(FLUSH_CYC);
            end else if (fcnt != 3'd0) begin
                fcnt <= fcnt - 3'd1;
            end
            if (hazard && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    assign cp0Bubble    = (fcnt != 3'd0);
    assign hazard       = ~cp0Bubble & (lu | mh);
    assign BranchBubble = ~cp0Bubble & ~hazard & id_branchTaken & id_valid;
    assign pc_stall     = hazard;
    assign ifid_stall   = hazard;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic against a time-stamp model.
module tb_pipe_hazard_ctrl;

    localparam int MUL_LAT   = 4;
    localparam int FLUSH_CYC = 2;
`ifdef PIPE_MUL_INTERLOCK_EN
    localparam bit MULEN = 1'b1;
`else
    localparam bit MULEN = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic [4:0]  id_Ra = '0, id_Rb = '0, ex_Rw = '0;
    logic        id_useRa = 1'b0, id_useRb = 1'b0, id_valid = 1'b0;
    logic        id_mulRead = 1'b0, id_mulCtr = 1'b0, id_branchTaken = 1'b0;
    logic [1:0]  id_regToMul = '0, ex_MemRead = '0;
    logic        ex_RegWr = 1'b0, ex_valid = 1'b0, ex_mulCtr = 1'b0, cp0_flush = 1'b0;
    logic        hazard, BranchBubble, cp0Bubble, pc_stall, ifid_stall, mul_busy;
    logic [15:0] stall_cnt;

    pipe_hazard_ctrl #(.MUL_LAT(MUL_LAT), .FLUSH_CYC(FLUSH_CYC)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .id_Ra(id_Ra), .id_Rb(id_Rb), .id_useRa(id_useRa), .id_useRb(id_useRb),
        .id_valid(id_valid), .id_mulRead(id_mulRead), .id_regToMul(id_regToMul),
        .id_mulCtr(id_mulCtr), .id_branchTaken(id_branchTaken),
        .ex_Rw(ex_Rw), .ex_RegWr(ex_RegWr), .ex_valid(ex_valid),
        .ex_MemRead(ex_MemRead), .ex_mulCtr(ex_mulCtr), .cp0_flush(cp0_flush),
        .hazard(hazard), .BranchBubble(BranchBubble), .cp0Bubble(cp0Bubble),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .mul_busy(mul_busy),
        .stall_cnt(stall_cnt)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: remember the cycle of the latest mult / flush request and derive windows from elapsed time.
    int cyc        = 0;
    int last_mult  = -1000;
    int last_flush = -1000;
    int scnt       = 0;
    bit m_lu, m_busy, m_cp0, m_haz, m_bb;

    always_comb begin
        m_lu   = ex_valid && ex_RegWr && (ex_MemRead != 0) && (ex_Rw != 0) && id_valid &&
                 ((id_useRa && id_Ra == ex_Rw) || (id_useRb && id_Rb == ex_Rw));
        m_busy = MULEN && (cyc - last_mult >= 1) && (cyc - last_mult <= MUL_LAT);
        m_cp0  = (cyc - last_flush >= 1) && (cyc - last_flush <= FLUSH_CYC);
        m_haz  = !m_cp0 && (m_lu || (m_busy && id_valid && (id_mulRead || id_mulCtr || id_regToMul != 0)));
        m_bb   = !m_cp0 && !m_haz && id_branchTaken && id_valid;
    end

    always @(posedge Clk) begin
        if (!Rst_n) begin
            last_mult  <= -1000;
            last_flush <= -1000;
            scnt       <= 0;
        end else begin
            if (ex_valid && ex_mulCtr) last_mult <= cyc;
            if (cp0_flush) last_flush <= cyc;
            if (m_haz && scnt < 65535) scnt <= scnt + 1;
        end
        cyc <= cyc + 1;
    end

    bit chk_en = 1'b0;
    always @(negedge Clk) begin
        if (chk_en) begin
            chk("m_hazard", 32'(hazard), 32'(m_haz));
            chk("m_branch", 32'(BranchBubble), 32'(m_bb));
            chk("m_cp0", 32'(cp0Bubble), 32'(m_cp0));
            chk("m_pcstall", 32'(pc_stall), 32'(m_haz));
            chk("m_ifidstall", 32'(ifid_stall), 32'(m_haz));
            chk("m_busy", 32'(mul_busy), 32'(m_busy));
            chk("m_stallcnt", 32'(stall_cnt), 32'(scnt));
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        id_Ra = '0; id_Rb = '0; id_useRa = 0; id_useRb = 0; id_valid = 0;
        id_mulRead = 0; id_regToMul = '0; id_mulCtr = 0; id_branchTaken = 0;
        ex_Rw = '0; ex_RegWr = 0; ex_valid = 0; ex_MemRead = '0; ex_mulCtr = 0;
        cp0_flush = 0;
    endtask

    task automatic set_lu();
        ex_valid = 1; ex_RegWr = 1; ex_MemRead = 2'b01; ex_Rw = 5'd8;
        id_valid = 1; id_Ra = 5'd8; id_useRa = 1;
    endtask

    int base_cnt;

    initial begin
        idle();
        Rst_n = 0;
        step(); step();
        Rst_n = 1;
        chk_en = 1;
        step();
        @(negedge Clk);
        chk("rst_hazard", 32'(hazard), 0);
        chk("rst_busy", 32'(mul_busy), 0);
        chk("rst_cp0", 32'(cp0Bubble), 0);
        chk("rst_stallcnt", 32'(stall_cnt), 0);

        // Load-use: one stall cycle, then the bubble removes the load from EX.
        step();
        set_lu();
        @(negedge Clk);
        chk("lu_hazard", 32'(hazard), 1);
        chk("lu_pcstall", 32'(pc_stall), 1);
        chk("lu_ifidstall", 32'(ifid_stall), 1);
        step();
        ex_MemRead = 2'b00;
        @(negedge Clk);
        chk("lu_release", 32'(hazard), 0);
        chk("lu_stallcnt", 32'(stall_cnt), 1);
        step();
        ex_MemRead = 2'b01; ex_Rw = 5'd0; id_Ra = 5'd0;
        @(negedge Clk);
        chk("lu_r0", 32'(hazard), 0);

        // Multiplier interlock with an mfhi waiting in ID.
        step();
        idle();
        ex_valid = 1; ex_mulCtr = 1;
        @(negedge Clk);
        chk("mul_t0_busy", 32'(mul_busy), 0);
        step();
        idle();
        id_valid = 1; id_mulRead = 1;
        for (int k = 1; k <= MUL_LAT; k++) begin
            @(negedge Clk);
            chk("mul_hazard", 32'(hazard), 32'(MULEN));
            chk("mul_busy", 32'(mul_busy), 32'(MULEN));
            step();
        end
        @(negedge Clk);
        chk("mul_issue", 32'(hazard), 0);
        chk("mul_done", 32'(mul_busy), 0);
        chk("mul_stallcnt", 32'(stall_cnt), 32'(1 + MUL_LAT * int'(MULEN)));

        // Flush during a load-use: bubble wins for FLUSH_CYC cycles.
        step();
        idle();
        set_lu();
        cp0_flush = 1;
        @(negedge Clk);
        chk("fl_pre_hazard", 32'(hazard), 1);
        step();
        cp0_flush = 0;
        @(negedge Clk);
        chk("fl_cp0_1", 32'(cp0Bubble), 1);
        chk("fl_haz_1", 32'(hazard), 0);
        step();
        @(negedge Clk);
        chk("fl_cp0_2", 32'(cp0Bubble), 1);
        chk("fl_haz_2", 32'(hazard), 0);
        step();
        @(negedge Clk);
        chk("fl_cp0_end", 32'(cp0Bubble), 0);
        chk("fl_haz_back", 32'(hazard), 1);

        // Back-to-back flush requests extend the window by one cycle.
        step();
        idle();
        cp0_flush = 1;
        step();
        @(negedge Clk);
        chk("fx_cp0_1", 32'(cp0Bubble), 1);
        step();
        cp0_flush = 0;
        @(negedge Clk);
        chk("fx_cp0_2", 32'(cp0Bubble), 1);
        step();
        @(negedge Clk);
        chk("fx_cp0_3", 32'(cp0Bubble), 1);
        step();
        @(negedge Clk);
        chk("fx_cp0_4", 32'(cp0Bubble), 0);

        // Taken branch, alone and together with a load-use.
        step();
        idle();
        id_valid = 1; id_branchTaken = 1;
        @(negedge Clk);
        chk("br_bubble", 32'(BranchBubble), 1);
        step();
        set_lu();
        @(negedge Clk);
        chk("br_lu_bubble", 32'(BranchBubble), 0);
        chk("br_lu_hazard", 32'(hazard), 1);

        // Reset in the second cycle of an in-flight multiply.
        step();
        idle();
        ex_valid = 1; ex_mulCtr = 1;
        step();
        idle();
        @(negedge Clk);
        chk("rm_busy_pre", 32'(mul_busy), 32'(MULEN));
        step();
        Rst_n = 0;
        step();
        Rst_n = 1;
        @(negedge Clk);
        chk("rm_busy", 32'(mul_busy), 0);
        chk("rm_stallcnt", 32'(stall_cnt), 0);

        // Randomized traffic with small register numbers so dependencies are frequent.
        for (int n = 0; n < 3000; n++) begin
            step();
            Rst_n          = ($urandom_range(0, 63) != 0);
            id_Ra          = 5'($urandom_range(0, 3));
            id_Rb          = 5'($urandom_range(0, 3));
            id_useRa       = 1'($urandom_range(0, 1));
            id_useRb       = 1'($urandom_range(0, 1));
            id_valid       = ($urandom_range(0, 7) != 0);
            id_mulRead     = ($urandom_range(0, 3) == 0);
            id_mulCtr      = ($urandom_range(0, 7) == 0);
            id_regToMul    = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            id_branchTaken = ($urandom_range(0, 3) == 0);
            ex_Rw          = 5'($urandom_range(0, 3));
            ex_RegWr       = 1'($urandom_range(0, 1));
            ex_valid       = ($urandom_range(0, 7) != 0);
            ex_MemRead     = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            ex_mulCtr      = ($urandom_range(0, 9) == 0);
            cp0_flush      = ($urandom_range(0, 15) == 0);
        end

        step();
        idle();
        Rst_n = 1;
        base_cnt = scnt;
        step();
        @(negedge Clk);
        chk_en = 0;
        chk("end_stallcnt", 32'(stall_cnt), 32'(base_cnt));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline interlock and flush controller for the five-stage MIPS core. It produces the `hazard`, `BranchBubble` and `cp0Bubble` controls consumed by the ID/EX pipeline register, plus the matching PC and IF/ID stall enables. It handles these conditions:
- load-use dependencies;
- multi-cycle multiplier occupancy (HI/LO interlock);
- taken-branch squash;
- multi-cycle CP0 exception/ERET flushes.

It sits beside the decode stage and observes both ID-stage and EX-stage fields.

## Interface
Parameters:
- `MUL_LAT`, 4: multiplier occupancy in cycles after a mult/multu enters EX, range 1..15.
- `FLUSH_CYC`, 2: number of cycles `cp0Bubble` stays asserted per flush request, range 1..7.

Ports:
- `Clk` input 1: core clock. State updates on posedge; all outputs are stable before the negedge at which the ID/EX register samples.
- `Rst_n` input 1: reset, synchronous, active-low.
- `id_Ra`, `id_Rb` input 5 each: source register numbers of the instruction in ID.
- `id_useRa`, `id_useRb` input 1 each: the ID instruction actually reads Ra / Rb.
- `id_valid` input 1: the ID instruction is valid.
- `id_mulRead` input 1: ID instruction is mfhi/mflo.
- `id_regToMul` input 2: ID instruction is mthi/mtlo when nonzero.
- `id_mulCtr` input 1: ID instruction is mult/multu.
- `id_branchTaken` input 1: a branch or jump in ID resolves taken.
- `ex_Rw` input 5: destination register of the EX instruction.
- `ex_RegWr`, `ex_valid` input 1 each: EX writes a register; EX is valid.
- `ex_MemRead` input 2: EX instruction is a load when nonzero.
- `ex_mulCtr` input 1: EX instruction is mult/multu.
- `cp0_flush` input 1: single-cycle request from CP0 (exception or ERET).
- `hazard` output 1: stall IF and ID, and insert a bubble into ID/EX.
- `BranchBubble` output 1: squash the ID/EX slot after a taken branch.
- `cp0Bubble` output 1: flush the ID/EX slot.
- `pc_stall`, `ifid_stall` output 1 each: hold the PC and the IF/ID register.
- `mul_busy` output 1: multiplier occupancy counter is nonzero.
- `stall_cnt` output 16: saturating count of cycles in which `hazard` was asserted.

## Operation
Load-use detection, combinational:
- `lu = ex_valid & ex_RegWr & (ex_MemRead!=0) & (ex_Rw!=0) & id_valid & ((id_useRa & id_Ra==ex_Rw) | (id_useRb & id_Rb==ex_Rw))`.

Multiplier interlock:
- 4-bit counter `mcnt`.
- At posedge with `ex_valid & ex_mulCtr`, `mcnt` loads `MUL_LAT`. This reload takes precedence over decrement.
- Otherwise, if `mcnt!=0`, `mcnt` decrements by 1.
- `mul_busy = (mcnt!=0)`.
- `mh = mul_busy & id_valid & (id_mulRead | id_mulCtr | id_regToMul!=0)`.

CP0 flush:
- 3-bit counter `fcnt`.
- At posedge with `cp0_flush`, `fcnt` loads `FLUSH_CYC`. A request arriving while `fcnt` is active reloads it (extends the flush).
- Otherwise, if `fcnt!=0`, `fcnt` decrements by 1.
- `cp0Bubble = (fcnt!=0)`.

Output priority:
- `hazard = ~cp0Bubble & (lu | mh)`.
- `BranchBubble = ~cp0Bubble & ~hazard & id_branchTaken & id_valid`.
- `pc_stall = ifid_stall = hazard`.

Other rules:
- `cp0_flush` does not clear `mcnt`; a multiply already in flight completes.
- `stall_cnt` increments at each posedge where `hazard` is 1 and saturates at 16'hFFFF.

## Timing
- Reset (`Rst_n` low at posedge) clears `mcnt`, `fcnt` and `stall_cnt` to 0. After reset, `mul_busy=0` and `cp0Bubble=0`.
- With inactive inputs after reset, all outputs are 0.
- Reset asserted mid-multiply or mid-flush aborts the operation immediately; outputs are 0 in the following cycle.
- A load-use stall lasts exactly 1 cycle: once the bubble enters EX, `ex_MemRead` drops to 0.
- A multiply stall: a mult entering EX at cycle t gives `mul_busy` high for cycles t+1..t+MUL_LAT. A dependent mfhi held in ID issues at t+MUL_LAT+1.
- Flush: `cp0_flush` at cycle t gives `cp0Bubble` high for cycles t+1..t+FLUSH_CYC.
- During `cp0Bubble`, `hazard` and `BranchBubble` are 0, so the redirect is never blocked by a stall.
- `BranchBubble` is combinational and asserts in the same cycle as `id_branchTaken`.

## Configuration
- `PIPE_MUL_INTERLOCK_EN` defined: the multiplier counter and `mh` term are present, as described above.
- `PIPE_MUL_INTERLOCK_EN` undefined:
  - `mcnt` is not instantiated;
  - `mul_busy` is tied to 0 and `mh` is 0;
  - HI/LO hazards become the responsibility of software scheduling;
  - all other behaviour is unchanged.

## Test plan
- **Load-use stall:** `ex_MemRead=2'b01`, `ex_Rw=5'd8`, `ex_RegWr=1`, `id_Ra=8`, `id_useRa=1` → `hazard`, `pc_stall` and `ifid_stall` are 1 for one cycle and `stall_cnt` becomes 1. With `ex_Rw=0` → no stall.
- **Multiplier interlock (`MUL_LAT=4`):** mult in EX at cycle 10, mfhi in ID from cycle 11 → `hazard` is high for cycles 11–14 and low at 15. `mul_busy` is high for 11–14.
- **Flush (`FLUSH_CYC=2`):** `cp0_flush` pulse at cycle 5 while `lu` is true → `cp0Bubble` is high at 6–7 and `hazard` is 0 during 6–7. A second pulse at cycle 6 extends `cp0Bubble` through cycle 8.
- **Taken branch:** `id_branchTaken=1`, no hazard → `BranchBubble=1` in the same cycle. If `lu` is also true → `BranchBubble=0` and `hazard=1`.
- **Reset mid-operation:** `Rst_n=0` at cycle 2 of a 4-cycle multiply → `mul_busy=0` next cycle and `stall_cnt=0`.
- **Compile without `PIPE_MUL_INTERLOCK_EN`:** run the multiplier-interlock stimulus → `hazard` stays 0 and `mul_busy` stays 0.
